led_share_arbiter: RTL

- Shares one board LED between N_REQ requesters, each asking for a blink at its own rate.
- Contains a free-running tick prescaler and a round-robin time-slot scheduler.
- Contains a per-grant blink phase generator.
- Sits between status sources (UART, heartbeat, error flags) and the single LED pin. The LED shows only the current owner's blink pattern.

---
 rtl/led_share_if.sv | 15 +
 rtl/led_share_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/led_share_if.sv
// Handshake bundle between the status sources and the shared-LED arbiter.
// The master side drives requests and rates; the slave side returns grant/led/busy.
interface led_share_if #(
    parameter int N_REQ  = 4,
    parameter int RATE_W = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*RATE_W-1:0] rate;
    logic [N_REQ-1:0]        grant;
    logic                    led;
    logic                    busy;

    modport master (output req, rate, input grant, led, busy);
    modport slave  (input req, rate, output grant, led, busy);
endinterface

// File: rtl/led_share_arbiter.sv
// Shares one LED between N_REQ requesters: a free-running tick prescaler drives a
// round-robin slot scheduler and a per-grant blink phase generator.
module led_share_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = 9,
    parameter int SLOT_TICKS = 8,
    parameter int RATE_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    led_share_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int SW = $clog2(SLOT_TICKS + 1);
    localparam int HW = RATE_W + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_n;
    logic [31:0]       presc;
    logic              tick;
    logic [PW-1:0]     ptr, ptr_n, owner, owner_n, winner;
    logic              found;
    logic [RATE_W-1:0] win_rate;
    logic [N_REQ-1:0]  grant_q, grant_n;
    logic              led_q, led_n, busy_q;
    logic [HW-1:0]     phase, phase_n, half, half_n;
    logic [SW-1:0]     slot, slot_n;
    logic              take, drop;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % N_REQ);
    endfunction

    assign tick = (presc == 32'(TICK_DIV));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc <= '0;
        else     presc <= tick ? '0 : presc + 32'd1;
    end

    // Rotating priority: first set request at or after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req[wrap(int'(ptr) + i)]) begin
                found  = 1'b1;
                winner = wrap(int'(ptr) + i);
            end
        end
    end

    assign win_rate = bus.rate[int'(winner)*RATE_W +: RATE_W];

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        grant_n = grant_q;
        led_n   = led_q;
        phase_n = phase;
        half_n  = half;
        slot_n  = slot;
        take    = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: take = found;
            GRANT: begin
                if (!bus.req[owner]) begin
                    take = found;
                    drop = !found;
                end else if (tick) begin
                    phase_n = phase - HW'(1);
                    if (phase == HW'(1)) begin
                        led_n   = ~led_q;
                        phase_n = half;
                    end
                    slot_n = slot - SW'(1);
                    // Sole requester keeps blinking without a restart on slot expiry.
                    if (slot == SW'(1)) begin
                        if (winner != owner) take = 1'b1;
                        else                 slot_n = SW'(SLOT_TICKS);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (take) begin
            state_n = GRANT;
            owner_n = winner;
            ptr_n   = wrap(int'(winner) + 1);
            grant_n = N_REQ'(1) << winner;
            led_n   = 1'b1;
            half_n  = HW'(win_rate) + HW'(1);
            phase_n = HW'(win_rate) + HW'(1);
            slot_n  = SW'(SLOT_TICKS);
        end else if (drop) begin
            state_n = IDLE;
            grant_n = '0;
            led_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            grant_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            phase   <= '0;
            half    <= '0;
            slot    <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            grant_q <= grant_n;
            led_q   <= led_n;
            busy_q  <= (grant_n != '0);
            phase   <= phase_n;
            half    <= half_n;
            slot    <= slot_n;
        end
    end

    assign bus.grant = grant_q;
    assign bus.led   = led_q;
    assign bus.busy  = busy_q;
endmodule
